multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
- Multi-cycle MIPS-subset control unit; drives the ALU operation select and samples the ALU `zero` flag.
- Sequences each instruction through IF/ID/EXE/MEM/WB states and issues per-state datapath strobes.
- Sits beside the datapath (PC, instruction register, register file, ALU, data memory) in the multi-cycle CPU.

Parameters:
- none (opcode map and state encoding are fixed below)

Ports:
- CLK  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- opcode  input  6  instruction register bits [31:26]
- zero  input  1  ALU flag, 1 when ALU result == 0
- ALUOp  output  3  ALU operation: 000 A+B, 001 A-B, 011 A|B, 100 A&B
- ALUSrcB  output  1  0 = rt data, 1 = extended immediate
- ExtSel  output  1  0 = zero-extend, 1 = sign-extend
- RegDst  output  1  0 = rt, 1 = rd as write register
- RegWre  output  1  register file write enable
- ALUM2Reg  output  1  0 = ALU result, 1 = memory data to register
- DataMemRW  output  1  1 = data memory write
- IRWre  output  1  instruction register load enable
- PCWre  output  1  PC load enable
- PCSrc  output  2  00 PC+4, 01 PC+4+(imm<<2), 10 jump target
- state  output  3  current state code, for debug

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010
  - sw 110000, lw 110001, beq 110100, j 111000, halt 111111
  - any other opcode = nop
- States and codes: IF 000, ID 001, EXE_AL 110, EXE_BR 101, EXE_LS 010, MEM 011, WB_AL 111, WB_LD 100. HALT reuses code 000 internally via a separate halted flag; `state` reads 000 while halted.
- Transitions:
  - IF -> ID always.
  - ID: j / nop -> IF; halt -> HALT; beq -> EXE_BR; lw/sw -> EXE_LS; arithmetic/logic -> EXE_AL.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM; MEM -> WB_LD for lw, IF for sw; WB_LD -> IF.
  - HALT: absorbing until Reset.
- Per-state outputs (Moore except PCSrc in EXE_BR); any strobe not listed below is 0:
  - IF: IRWre=1.
  - ID, j/nop: PCWre=1; PCSrc=10 for j, 00 for nop.
  - EXE_AL: ALUOp per opcode (add/addi 000, sub 001, or/ori 011, and 100); ALUSrcB=1 for addi/ori; ExtSel=1 for addi, 0 for ori.
  - WB_AL: same ALU controls held; RegWre=1; RegDst=1 for R-type, 0 for immediates; ALUM2Reg=0; PCWre=1; PCSrc=00.
  - EXE_BR: ALUOp=001; ALUSrcB=0; ExtSel=1; PCWre=1; PCSrc=01 if zero==1 else 00. zero is sampled combinationally in the same cycle.
  - EXE_LS: ALUOp=000; ALUSrcB=1; ExtSel=1.
  - MEM: address controls held. sw: DataMemRW=1, PCWre=1, PCSrc=00. lw: DataMemRW=0.
  - WB_LD: RegWre=1; RegDst=0; ALUM2Reg=1; PCWre=1; PCSrc=00.
- Exactly one PCWre pulse per instruction; IRWre only in IF; PCWre and RegWre are never both asserted in IF or ID.
- Latencies in cycles: j/nop 2, beq 3, arithmetic/logic 4, sw 4, lw 5.
- Reset:
  - Asynchronous, active-low. Forces state=IF, halted=0, and all outputs to 0 immediately, including mid-instruction.
  - First rising edge after deassertion leaves IF for ID.
- opcode is sampled only as the instruction register holds it; it is stable from ID through the end of the instruction.

Test Plan:
- Reset low mid-EXE_AL -> outputs all 0 and state=000 before the next edge; after release, IRWre=1 in the first cycle.
- add (000000) -> states 000,001,110,111; WB_AL shows ALUOp=000, RegDst=1, RegWre=1, PCWre=1, PCSrc=00; next cycle IF.
- beq (110100) with zero=1 -> EXE_BR shows ALUOp=001, PCSrc=01, PCWre=1; repeat with zero=0 -> PCSrc=00.
- lw (110001) -> 5 cycles, states 000,001,010,011,100; WB_LD shows ALUM2Reg=1, RegWre=1; sw (110000) -> MEM shows DataMemRW=1, PCWre=1, then IF.
- ori (010010) -> EXE_AL shows ALUOp=011, ALUSrcB=1, ExtSel=0; j (111000) -> ID shows PCWre=1, PCSrc=10, back to IF after 2 cycles.
- halt (111111) -> PCWre stays 0 for 20 cycles and state=000; unknown opcode 101010 -> 2-cycle nop, PCSrc=00.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-subset control unit.
// Sequences IF/ID/EXE/MEM/WB and issues datapath strobes.
module multi_cycle_control (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] ALUOp,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic       RegDst,
    output logic       RegWre,
    output logic       ALUM2Reg,
    output logic       DataMemRW,
    output logic       IRWre,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_halted;
    logic   w_halted_next;

    logic w_add, w_sub, w_addi, w_or, w_and, w_ori;
    logic w_sw, w_lw, w_beq, w_j, w_halt;
    logic w_is_al, w_is_imm, w_is_ls;
    logic [2:0] w_al_op;

    assign w_add  = (opcode == 6'b000000);
    assign w_sub  = (opcode == 6'b000001);
    assign w_addi = (opcode == 6'b000010);
    assign w_or   = (opcode == 6'b010000);
    assign w_and  = (opcode == 6'b010001);
    assign w_ori  = (opcode == 6'b010010);
    assign w_sw   = (opcode == 6'b110000);
    assign w_lw   = (opcode == 6'b110001);
    assign w_beq  = (opcode == 6'b110100);
    assign w_j    = (opcode == 6'b111000);
    assign w_halt = (opcode == 6'b111111);

    assign w_is_imm = w_addi | w_ori;
    assign w_is_al  = w_add | w_sub | w_or | w_and | w_is_imm;
    assign w_is_ls  = w_sw | w_lw;

    assign w_al_op = w_sub            ? 3'b001 :
                     (w_or | w_ori)   ? 3'b011 :
                     w_and            ? 3'b100 : 3'b000;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_IF;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_halted <= w_halted_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_halted_next = r_halted;
        if (!r_halted) begin
            unique case (r_state)
                S_IF: w_next = S_ID;
                S_ID: begin
                    unique case (1'b1)
                        w_halt: begin
                            w_halted_next = 1'b1;
                            w_next        = S_IF;
                        end
                        w_beq:   w_next = S_EXE_BR;
                        w_is_ls: w_next = S_EXE_LS;
                        w_is_al: w_next = S_EXE_AL;
                        default: w_next = S_IF;
                    endcase
                end
                S_EXE_AL: w_next = S_WB_AL;
                S_WB_AL:  w_next = S_IF;
                S_EXE_BR: w_next = S_IF;
                S_EXE_LS: w_next = S_MEM;
                S_MEM:    w_next = w_lw ? S_WB_LD : S_IF;
                S_WB_LD:  w_next = S_IF;
                default:  w_next = S_IF;
            endcase
        end
    end

    // Strobes are gated by Reset so they drop without waiting for an edge.
    always_comb begin
        ALUOp     = 3'b000;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        RegDst    = 1'b0;
        RegWre    = 1'b0;
        ALUM2Reg  = 1'b0;
        DataMemRW = 1'b0;
        IRWre     = 1'b0;
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        if (Reset && !r_halted) begin
            unique case (r_state)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    if (w_j) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end else if (!(w_halt | w_beq | w_is_ls | w_is_al)) begin
                        PCWre = 1'b1;
                    end
                end
                S_EXE_AL: begin
                    ALUOp   = w_al_op;
                    ALUSrcB = w_is_imm;
                    ExtSel  = w_addi;
                end
                S_WB_AL: begin
                    ALUOp   = w_al_op;
                    ALUSrcB = w_is_imm;
                    ExtSel  = w_addi;
                    RegWre  = 1'b1;
                    RegDst  = !w_is_imm;
                    PCWre   = 1'b1;
                end
                S_EXE_BR: begin
                    ALUOp  = 3'b001;
                    ExtSel = 1'b1;
                    PCWre  = 1'b1;
                    PCSrc  = zero ? 2'b01 : 2'b00;
                end
                S_EXE_LS: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                end
                S_MEM: begin
                    ALUSrcB   = 1'b1;
                    ExtSel    = 1'b1;
                    DataMemRW = w_sw;
                    PCWre     = w_sw;
                end
                S_WB_LD: begin
                    RegWre   = 1'b1;
                    ALUM2Reg = 1'b1;
                    PCWre    = 1'b1;
                end
                default: IRWre = 1'b0;
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control.
// Per-instruction cycle model plus hand-computed pins.
module tb_multi_cycle_control;

    typedef struct packed {
        logic [2:0] aluop;
        logic       srcb;
        logic       ext;
        logic       regdst;
        logic       regwre;
        logic       m2r;
        logic       memw;
        logic       irwre;
        logic       pcwre;
        logic [1:0] pcsrc;
        logic [2:0] st;
    } vec_t;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] ALUOp;
    logic       ALUSrcB, ExtSel, RegDst, RegWre;
    logic       ALUM2Reg, DataMemRW, IRWre, PCWre;
    logic [1:0] PCSrc;
    logic [2:0] state;

    vec_t  got;
    vec_t  exp_v;
    logic  exp_valid = 1'b0;
    string tag = "reset";
    int    n_tests = 0;
    int    n_fail = 0;

    multi_cycle_control dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
        .RegDst(RegDst), .RegWre(RegWre), .ALUM2Reg(ALUM2Reg),
        .DataMemRW(DataMemRW), .IRWre(IRWre), .PCWre(PCWre),
        .PCSrc(PCSrc), .state(state)
    );

    always #5 CLK = ~CLK;

    assign got = vec_t'({ALUOp, ALUSrcB, ExtSel, RegDst, RegWre,
                         ALUM2Reg, DataMemRW, IRWre, PCWre,
                         PCSrc, state});

    function automatic vec_t mk(
        input logic [2:0] a, input logic sb, input logic ex,
        input logic rd, input logic rw, input logic mr,
        input logic mw, input logic ir, input logic pw,
        input logic [1:0] ps, input logic [2:0] st);
        vec_t v;
        v = '{a, sb, ex, rd, rw, mr, mw, ir, pw, ps, st};
        return v;
    endfunction

    // Instruction class: 0 nop, 1 j, 2 halt, 3 beq, 4 alu, 5 sw, 6 lw
    function automatic int cls(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b000010,
            6'b010000, 6'b010001, 6'b010010: return 4;
            6'b110000: return 5;
            6'b110001: return 6;
            6'b110100: return 3;
            6'b111000: return 1;
            6'b111111: return 2;
            default:   return 0;
        endcase
    endfunction

    function automatic int lat(input logic [5:0] op);
        int l [7] = '{2, 2, 2, 3, 4, 4, 5};
        return l[cls(op)];
    endfunction

    // Expected outputs for cycle k of an instruction started in IF.
    function automatic vec_t model(input logic [5:0] op,
                                   input int k, input logic z);
        vec_t v;
        int   c;
        logic imm;
        c   = cls(op);
        imm = (op == 6'b000010) || (op == 6'b010010);
        v   = '0;
        if (k == 0) begin
            v.irwre = 1'b1;
            return v;
        end
        if (k == 1) begin
            v.st = 3'b001;
            if (c == 0) v.pcwre = 1'b1;
            if (c == 1) begin
                v.pcwre = 1'b1;
                v.pcsrc = 2'b10;
            end
            return v;
        end
        if (c == 2) return v;
        if (c == 3) begin
            v = mk(3'b001, 0, 1, 0, 0, 0, 0, 0, 1,
                   z ? 2'b01 : 2'b00, 3'b101);
        end else if (c == 4) begin
            case (op)
                6'b000001:           v.aluop = 3'b001;
                6'b010000, 6'b010010: v.aluop = 3'b011;
                6'b010001:           v.aluop = 3'b100;
                default:             v.aluop = 3'b000;
            endcase
            v.srcb = imm;
            v.ext  = (op == 6'b000010);
            v.st   = 3'b110;
            if (k == 3) begin
                v.st     = 3'b111;
                v.regwre = 1'b1;
                v.regdst = !imm;
                v.pcwre  = 1'b1;
            end
        end else if (k < 4) begin
            v.srcb = 1'b1;
            v.ext  = 1'b1;
            v.st   = (k == 2) ? 3'b010 : 3'b011;
            if (k == 3 && c == 5) begin
                v.memw  = 1'b1;
                v.pcwre = 1'b1;
            end
        end else begin
            v = mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 1, 2'b00, 3'b100);
        end
        return v;
    endfunction

    always @(negedge CLK) begin
        if (exp_valid) begin
            n_tests++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h",
                         tag, got, exp_v);
            end
        end
    end

    task automatic pin(input string nm, input vec_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL pin %s: got %h expected %h",
                     nm, got, want);
        end
    endtask

    // Runs ncyc cycles (-1 = whole instruction) from an IF cycle.
    task automatic run(input string nm, input logic [5:0] op,
                       input logic z, input int ncyc,
                       input int lk, input vec_t lit);
        int n;
        n = (ncyc < 0) ? lat(op) : ncyc;
        for (int k = 0; k < n; k++) begin
            opcode    = op;
            zero      = z;
            tag       = nm;
            exp_v     = model(op, k, z);
            exp_valid = 1'b1;
            if (k == lk) begin
                #1;
                pin(nm, lit);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        Reset     = 1'b0;
        opcode    = 6'b000000;
        zero      = 1'b0;
        exp_v     = '0;
        exp_valid = 1'b1;
        @(posedge CLK);
        #1;
        pin("reset", '0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;

        run("add", 6'b000000, 0, -1, 3,
            mk(3'b000, 0, 0, 1, 1, 0, 0, 0, 1, 2'b00, 3'b111));
        run("sub", 6'b000001, 1, -1, -1, '0);
        run("addi", 6'b000010, 0, -1, -1, '0);
        run("or", 6'b010000, 0, -1, -1, '0);
        run("and", 6'b010001, 0, -1, -1, '0);
        run("ori", 6'b010010, 0, -1, 2,
            mk(3'b011, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b110));
        run("beq_t", 6'b110100, 1, -1, 2,
            mk(3'b001, 0, 1, 0, 0, 0, 0, 0, 1, 2'b01, 3'b101));
        run("beq_nt", 6'b110100, 0, -1, 2,
            mk(3'b001, 0, 1, 0, 0, 0, 0, 0, 1, 2'b00, 3'b101));
        run("lw", 6'b110001, 1, -1, 4,
            mk(3'b000, 0, 0, 0, 1, 1, 0, 0, 1, 2'b00, 3'b100));
        run("sw", 6'b110000, 0, -1, 3,
            mk(3'b000, 1, 1, 0, 0, 0, 1, 0, 1, 2'b00, 3'b011));
        run("j", 6'b111000, 0, -1, 1,
            mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b001));
        run("nop", 6'b101010, 1, -1, 1,
            mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001));

        // Reset asserted while in EXE_AL
        run("add_pre", 6'b000000, 0, 2, -1, '0);
        pin("exe_al", mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0,
                         2'b00, 3'b110));
        exp_v = '0;
        tag   = "mid_reset";
        Reset = 1'b0;
        #1;
        pin("mid_reset", '0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        run("post_reset", 6'b000010, 0, -1, 0,
            mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000));

        run("halt", 6'b111111, 0, -1, -1, '0);
        for (int i = 0; i < 20; i++) begin
            opcode = (i[0]) ? 6'b000000 : 6'b111111;
            exp_v  = model(6'b111111, 2 + i, 1'b0);
            tag    = "halted";
            if (i == 10) begin
                #1;
                pin("halted", '0);
            end
            @(posedge CLK);
            #1;
        end

        exp_v = '0;
        tag   = "halt_reset";
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        run("recover", 6'b110001, 0, -1, -1, '0);

        exp_valid = 1'b0;
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
